// File: rtl/audio_tone_seq_pkg.sv
// -----------------------------------------------------------------------------
// audio_tone_seq_pkg
// Shared widths, note-table type and default tune for the frame-locked tone
// sequencer. Imported by the note ROM, the interface and the top level.
// -----------------------------------------------------------------------------
package audio_tone_seq_pkg;

  localparam int PWM_W   = 8;   // PWM counter, envelope and amplitude width
  localparam int HALF_W  = 16;  // note half-period width, in clk cycles
  localparam int SEQ_LEN = 16;  // steps in the sequence
  localparam int SEQ_W   = 4;   // width of a sequence index

  typedef logic [HALF_W-1:0] half_t;

  // Entry 0 is the leftmost field, so a plain concatenation lists step 0 first.
  typedef logic [0:SEQ_LEN-1][HALF_W-1:0] note_table_t;

  // C major scale up, one rest, then back down, at a 25.175 MHz pixel clock.
  // Each entry is clk / (2 * f_note); 0 marks a rest.
  localparam note_table_t NOTE_TABLE_DEFAULT = {
    16'd48112, 16'd42863, 16'd38187, 16'd36043,   // C4 D4 E4 F4
    16'd32111, 16'd28608, 16'd25487, 16'd24056,   // G4 A4 B4 C5
    16'd0,     16'd25487, 16'd28608, 16'd32111,   // rest B4 A4 G4
    16'd36043, 16'd38187, 16'd42863, 16'd48112    // F4 E4 D4 C4
  };

  // Envelope step-down that floors at zero instead of wrapping.
  function automatic logic [PWM_W-1:0] env_dec(input logic [PWM_W-1:0] env,
                                               input int step);
    if (int'(env) > step) return env - PWM_W'(step);
    return '0;
  endfunction

endpackage

// File: rtl/audio_tone_seq_if.sv
// -----------------------------------------------------------------------------
// audio_tone_seq_if
// Control and status bundle of the tone sequencer.
//   en, v_sync, volume        : playback enable, active-low frame sync, level
//   audio_pwm                 : registered PWM audio bit
//   note_idx, note_start      : current sequence step, one-cycle new-note pulse
// master = the side that drives the controls; slave = the sequencer itself.
// -----------------------------------------------------------------------------
interface audio_tone_seq_if;

  logic                               en;
  logic                               v_sync;
  logic [1:0]                         volume;
  logic                               audio_pwm;
  logic [audio_tone_seq_pkg::SEQ_W-1:0] note_idx;
  logic                               note_start;

  modport master (output en, v_sync, volume,
                  input  audio_pwm, note_idx, note_start);

  modport slave  (input  en, v_sync, volume,
                  output audio_pwm, note_idx, note_start);

endinterface

// File: rtl/audio_note_rom.sv
// -----------------------------------------------------------------------------
// audio_note_rom
// Combinational lookup from sequence step to note half-period.
//   i_idx  : sequence step
//   o_half : half-period in clk cycles (0 = rest)
// -----------------------------------------------------------------------------
module audio_note_rom
  import audio_tone_seq_pkg::*;
#(
  parameter note_table_t TABLE = NOTE_TABLE_DEFAULT
) (
  input  logic [SEQ_W-1:0] i_idx,
  output half_t            o_half
);

  always_comb o_half = TABLE[i_idx];

endmodule

// File: rtl/audio_tone_seq.sv
// -----------------------------------------------------------------------------
// audio_tone_seq
// Frame-locked square-wave tune player with a decaying envelope and 8-bit PWM
// output. Each note lasts NOTE_FRAMES video frames; the envelope drops by
// ENV_STEP per frame and restarts at full scale on every new note.
//   clk  : pixel clock, all logic on its rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of audio_tone_seq_if (en, v_sync, volume in;
//          audio_pwm, note_idx, note_start out)
// -----------------------------------------------------------------------------
module audio_tone_seq
  import audio_tone_seq_pkg::*;
#(
  parameter int          NOTE_FRAMES = 15,
  parameter int          ENV_STEP    = 16,
  parameter note_table_t NOTE_TABLE  = NOTE_TABLE_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  audio_tone_seq_if.slave  bus
);

  localparam int                 FRAME_W    = (NOTE_FRAMES > 1) ? $clog2(NOTE_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NOTE_FRAMES - 1);

  logic               r_vsync;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [SEQ_W-1:0]   r_note_idx;
  logic               r_note_start;
  half_t              r_tone_cnt;
  logic               r_sq;
  logic [PWM_W-1:0]   r_env;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic               r_audio_pwm;

  half_t              w_half;
  logic               w_frame_tick;
  logic               w_tick_en;
  logic               w_note_adv;
  logic               w_tone_wrap;
  logic [PWM_W-1:0]   w_amp;
  logic               w_pwm_bit;

  audio_note_rom #(
    .TABLE (NOTE_TABLE)
  ) u_note_rom (
    .i_idx  (r_note_idx),
    .o_half (w_half)
  );

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path through
    // this block can leave one unassigned and infer a latch.
    w_frame_tick = 1'b0;
    w_tick_en    = 1'b0;
    w_note_adv   = 1'b0;
    w_tone_wrap  = 1'b0;
    w_amp        = '0;
    w_pwm_bit    = 1'b0;

    // Falling edge of the active-low sync: previous sample high, current low.
    w_frame_tick = r_vsync & ~bus.v_sync;
    // A tick that lands while playback is off is dropped, not deferred.
    w_tick_en    = w_frame_tick & bus.en;
    w_note_adv   = w_tick_en & (r_frame_cnt == FRAME_LAST);
    w_tone_wrap  = (r_tone_cnt == w_half - 16'd1);

    if (r_sq) w_amp = r_env >> (2'd3 - bus.volume);

    // Gating with en silences the output one cycle after en drops, before
    // the square wave itself has been cleared.
    w_pwm_bit = bus.en & (r_pwm_cnt < w_amp);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register here sample the
    // pre-edge values, independent of statement order.
    if (rst) begin
      r_vsync      <= 1'b1;
      r_frame_cnt  <= '0;
      r_note_idx   <= '0;
      r_note_start <= 1'b0;
      r_tone_cnt   <= '0;
      r_sq         <= 1'b0;
      r_env        <= '1;
      r_pwm_cnt    <= '0;
      r_audio_pwm  <= 1'b0;
    end else begin
      r_vsync      <= bus.v_sync;
      r_pwm_cnt    <= r_pwm_cnt + PWM_W'(1);
      r_audio_pwm  <= w_pwm_bit;
      // Registered so the pulse lines up with the cycle note_idx changes.
      r_note_start <= w_note_adv;

      if (w_tick_en) r_frame_cnt <= w_note_adv ? '0 : r_frame_cnt + FRAME_W'(1);
      if (w_note_adv) r_note_idx <= r_note_idx + SEQ_W'(1);

      // The frame that starts a note reloads the envelope instead of decaying it.
      if (w_note_adv)     r_env <= '1;
      else if (w_tick_en) r_env <= env_dec(r_env, ENV_STEP);

      // A new note, a rest or paused playback all park the oscillator at 0,
      // so every note begins from the same phase.
      if (w_note_adv || !bus.en || (w_half == '0)) begin
        r_tone_cnt <= '0;
        r_sq       <= 1'b0;
      end else if (w_tone_wrap) begin
        r_tone_cnt <= '0;
        r_sq       <= ~r_sq;
      end else begin
        r_tone_cnt <= r_tone_cnt + 16'd1;
      end
    end
  end

  assign bus.audio_pwm  = r_audio_pwm;
  assign bus.note_idx   = r_note_idx;
  assign bus.note_start = r_note_start;

endmodule

// File: tb/tb_audio_tone_seq.sv
// -----------------------------------------------------------------------------
// tb_audio_tone_seq
// Directed bench for audio_tone_seq. dut_a: NOTE_FRAMES=2, ENV_STEP=64;
// dut_b: NOTE_FRAMES=8, ENV_STEP=64. Both use a short test table whose first
// entries are 4, 0, 6 and whose step 3 is long enough to hold sq high for a
// full 256-cycle PWM period.
// -----------------------------------------------------------------------------
module tb_audio_tone_seq;
  import audio_tone_seq_pkg::*;

  localparam note_table_t TEST_TABLE = {
    16'd4, 16'd0, 16'd6, 16'd1000,
    16'd5, 16'd3, 16'd0, 16'd7,
    16'd5, 16'd2, 16'd9, 16'd0,
    16'd4, 16'd8, 16'd3, 16'd5
  };

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  audio_tone_seq_if bus_a ();
  audio_tone_seq_if bus_b ();

  audio_tone_seq #(
    .NOTE_FRAMES (2),
    .ENV_STEP    (64),
    .NOTE_TABLE  (TEST_TABLE)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  audio_tone_seq #(
    .NOTE_FRAMES (8),
    .ENV_STEP    (64),
    .NOTE_TABLE  (TEST_TABLE)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; return at the falling edge, away from the active edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One active-low sync pulse (2 cycles low, 2 high); counts note_start pulses.
  task automatic vsync_pulse(input bit on_b, output int starts);
    starts = 0;
    if (on_b) bus_b.v_sync = 1'b0; else bus_a.v_sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (on_b ? bus_b.note_start : bus_a.note_start) starts++;
      if (i == 1) begin
        if (on_b) bus_b.v_sync = 1'b1; else bus_a.v_sync = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   starts, bad_sq, bad_pwm, hi, t, t1, t2, toggles;
    int   exp_idx, exp_frame, exp_start;
    logic exp_pwm, prev;
    bit   found, wrapped;
    logic [7:0] env_seq [5];

    rst_a = 1'b1;  rst_b = 1'b1;
    bus_a.en = 1'b1; bus_a.v_sync = 1'b1; bus_a.volume = 2'd3;
    bus_b.en = 1'b1; bus_b.v_sync = 1'b1; bus_b.volume = 2'd3;
    step(3);

    // ---- reset values ----
    check("rst_note_idx",   bus_a.note_idx,   0);
    check("rst_note_start", bus_a.note_start, 0);
    check("rst_audio_pwm",  bus_a.audio_pwm,  0);
    check("rst_env",        dut_a.r_env,      255);

    // ---- note 0 (H=4), env 255, volume 3: amp 255 whenever sq=1 ----
    rst_a = 1'b0;
    bad_sq = 0; bad_pwm = 0; hi = 0;
    for (int i = 1; i <= 264; i++) begin
      step();
      if (dut_a.r_sq !== 1'(((i >> 2) & 1))) bad_sq++;
      exp_pwm = (((i - 1) >> 2) & 1) == 1 && ((i - 1) % 256) != 255;
      if (bus_a.audio_pwm !== exp_pwm) bad_pwm++;
      if (i <= 256 && bus_a.audio_pwm) hi++;
    end
    check("n0_sq_toggle_mismatches", bad_sq, 0);
    check("n0_pwm_mismatches",       bad_pwm, 0);
    check("n0_pwm_high_of_256",      hi, 127);

    // ---- frame 1 of note 0, then advance into the rest ----
    vsync_pulse(1'b0, starts);
    check("f1_starts",   starts, 0);
    check("f1_note_idx", bus_a.note_idx, 0);
    check("f1_env",      dut_a.r_env, 191);
    vsync_pulse(1'b0, starts);
    check("n1_starts",   starts, 1);
    check("n1_note_idx", bus_a.note_idx, 1);
    check("n1_env",      dut_a.r_env, 255);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (bus_a.audio_pwm || dut_a.r_sq) hi++;
    end
    check("rest_silent", hi, 0);

    // ---- into note 2 (H=6): square period 12 ----
    vsync_pulse(1'b0, starts);
    check("n1f1_starts", starts, 0);
    vsync_pulse(1'b0, starts);
    check("n2_starts",   starts, 1);
    check("n2_note_idx", bus_a.note_idx, 2);
    t = 0; t1 = -1; t2 = -1; prev = dut_a.r_sq;
    while (t < 100 && t2 < 0) begin
      step(); t++;
      if (!prev && dut_a.r_sq) begin
        if (t1 < 0) t1 = t; else t2 = t;
      end
      prev = dut_a.r_sq;
    end
    check("n2_sq_period", t2 - t1, 12);

    // ---- note 3 (long H): duty at env 191, volume 3 then volume 1 ----
    vsync_pulse(1'b0, starts);
    vsync_pulse(1'b0, starts);
    check("n3_note_idx", bus_a.note_idx, 3);
    vsync_pulse(1'b0, starts);
    check("n3f1_env", dut_a.r_env, 191);
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      step();
      if (dut_a.r_sq) found = 1'b1;
    end
    check("n3_sq_high_seen", found, 1);
    step(2);
    hi = 0;
    for (int i = 0; i < 256; i++) begin step(); if (bus_a.audio_pwm) hi++; end
    check("vol3_pwm_high_of_256", hi, 191);
    bus_a.volume = 2'd1;
    step(2);
    hi = 0;
    for (int i = 0; i < 256; i++) begin step(); if (bus_a.audio_pwm) hi++; end
    check("vol1_pwm_high_of_256", hi, 47);
    bus_a.volume = 2'd3;

    // ---- run the sequence round to the 15 -> 0 wrap ----
    exp_idx = 3; exp_frame = 1; wrapped = 1'b0; bad_sq = 0;
    for (int p = 0; p < 40 && !wrapped; p++) begin
      vsync_pulse(1'b0, starts);
      if (exp_frame == 1) begin
        exp_frame = 0; exp_start = 1;
        exp_idx = (exp_idx + 1) % 16;
      end else begin
        exp_frame = 1; exp_start = 0;
      end
      if (starts != exp_start || bus_a.note_idx !== 4'(exp_idx)) bad_sq++;
      if (exp_start == 1 && exp_idx == 0) begin
        wrapped = 1'b1;
        check("wrap_note_idx",   bus_a.note_idx, 0);
        check("wrap_note_start", starts, 1);
        check("wrap_env",        dut_a.r_env, 255);
      end
    end
    check("seq_walk_mismatches", bad_sq, 0);
    check("wrap_reached", wrapped, 1);

    // ---- pause mid-note for three ticks (first tick coincides with en fall) ----
    vsync_pulse(1'b0, starts);
    check("pre_pause_env", dut_a.r_env, 191);
    bus_a.en = 1'b0;
    t = 0;
    for (int p = 0; p < 3; p++) begin
      vsync_pulse(1'b0, starts);
      t += starts;
    end
    check("pause_starts",    t, 0);
    check("pause_note_idx",  bus_a.note_idx, 0);
    check("pause_env",       dut_a.r_env, 191);
    check("pause_frame_cnt", dut_a.r_frame_cnt, 1);
    hi = 0;
    for (int i = 0; i < 32; i++) begin step(); if (bus_a.audio_pwm) hi++; end
    check("pause_pwm_silent", hi, 0);
    bus_a.en = 1'b1;
    t = 0;
    for (int i = 0; i < 8; i++) begin step(); if (bus_a.note_start) t++; end
    check("resume_no_start", t, 0);
    vsync_pulse(1'b0, starts);
    check("resume_adv_starts",   starts, 1);
    check("resume_adv_note_idx", bus_a.note_idx, 1);

    // ---- reset mid-note, with a sync edge in the same cycle ----
    vsync_pulse(1'b0, starts);
    rst_a = 1'b1; bus_a.v_sync = 1'b0;
    step();
    check("mid_rst_note_idx",   bus_a.note_idx,     0);
    check("mid_rst_note_start", bus_a.note_start,   0);
    check("mid_rst_audio_pwm",  bus_a.audio_pwm,    0);
    check("mid_rst_env",        dut_a.r_env,        255);
    check("mid_rst_frame_cnt",  dut_a.r_frame_cnt,  0);
    check("mid_rst_tone_cnt",   dut_a.r_tone_cnt,   0);
    check("mid_rst_sq",         dut_a.r_sq,         0);
    check("mid_rst_pwm_cnt",    dut_a.r_pwm_cnt,    0);
    bus_a.v_sync = 1'b1;
    step();
    rst_a = 1'b0;
    vsync_pulse(1'b0, starts);
    check("post_rst_f0_starts",   starts, 0);
    check("post_rst_f0_note_idx", bus_a.note_idx, 0);
    check("post_rst_f0_env",      dut_a.r_env, 191);
    vsync_pulse(1'b0, starts);
    check("post_rst_adv_starts",   starts, 1);
    check("post_rst_adv_note_idx", bus_a.note_idx, 1);

    // ---- dut_b: five ticks inside one 8-frame note saturate the envelope ----
    rst_b = 1'b0;
    step();
    env_seq = '{8'd191, 8'd127, 8'd63, 8'd0, 8'd0};
    t = 0; bad_sq = 0;
    for (int p = 0; p < 5; p++) begin
      vsync_pulse(1'b1, starts);
      t += starts;
      if (dut_b.r_env !== env_seq[p]) bad_sq++;
    end
    check("b_env_walk_mismatches", bad_sq, 0);
    check("b_env_final",  dut_b.r_env, 0);
    check("b_starts",     t, 0);
    check("b_note_idx",   bus_b.note_idx, 0);
    hi = 0; toggles = 0; prev = dut_b.r_sq;
    for (int i = 0; i < 64; i++) begin
      step();
      if (bus_b.audio_pwm) hi++;
      if (dut_b.r_sq !== prev) toggles++;
      prev = dut_b.r_sq;
    end
    check("b_pwm_silent", hi, 0);
    check("b_sq_running", toggles > 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
